// File: rtl/fft_unscramble_buffer.sv
// Ping-pong reorder buffer: takes frames in bit-reversed index order and
// re-emits each frame in natural order while the other bank fills.
module fft_unscramble_buffer #(
  parameter int SAMPLES = 4,
  parameter int WIDTH   = 4,
  parameter int IDX_W   = $clog2(SAMPLES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [IDX_W-1:0] out_index,
  output logic             out_last
);

  logic [WIDTH-1:0] bank_q [0:1][0:SAMPLES-1];
  logic [1:0]       full_q,    full_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0] wr_cnt_q,  wr_cnt_d;
  logic [IDX_W-1:0] rd_cnt_q,  rd_cnt_d;

  logic wr_fire, rd_fire, wr_last, rd_last;

  function automatic logic [IDX_W-1:0] bitrev(input logic [IDX_W-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < IDX_W; i++) begin
      r[i] = v[IDX_W-1-i];
    end
    return r;
  endfunction

  assign in_ready  = !full_q[wr_bank_q];
  assign out_valid = full_q[rd_bank_q];
  assign out_data  = bank_q[rd_bank_q][rd_cnt_q];
  assign out_index = rd_cnt_q;

  assign wr_fire  = in_valid && in_ready;
  assign rd_fire  = out_valid && out_ready;
  assign wr_last  = (wr_cnt_q == IDX_W'(SAMPLES - 1));
  assign rd_last  = (rd_cnt_q == IDX_W'(SAMPLES - 1));
  assign out_last = out_valid && rd_last;

  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    if (wr_fire) begin
      wr_cnt_d = wr_last ? '0 : wr_cnt_q + 1'b1;
      if (wr_last) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
      end
    end
    // Full flags gate each side, so the two updates always hit different banks.
    if (rd_fire) begin
      rd_cnt_d = rd_last ? '0 : rd_cnt_q + 1'b1;
      if (rd_last) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = !rd_bank_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q    <= '{default: '0};
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
    end else begin
      if (wr_fire) begin
        bank_q[wr_bank_q][bitrev(wr_cnt_q)] <= in_data;
      end
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
    end
  end

endmodule

// File: tb/tb_fft_unscramble_buffer.sv
// Directed bench for fft_unscramble_buffer: SAMPLES=4 main instance plus a SAMPLES=8 instance.
module tb_fft_unscramble_buffer;

  logic       clk;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready, out_last;
  logic [3:0] in_data, out_data;
  logic [1:0] out_index;

  logic       in_valid8, in_ready8, out_valid8, out_ready8, out_last8;
  logic [3:0] in_data8, out_data8;
  logic [2:0] out_index8;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned xfers  = 0;
  int unsigned exp_idx = 0;
  int unsigned x0;
  logic [3:0] expq [$];
  logic [3:0] exp8 [8] = '{4'd0, 4'd4, 4'd2, 4'd6, 4'd1, 4'd5, 4'd3, 4'd7};

  fft_unscramble_buffer #(.SAMPLES(4), .WIDTH(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last)
  );

  fft_unscramble_buffer #(.SAMPLES(8), .WIDTH(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
    .out_index(out_index8), .out_last(out_last8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Output-side scoreboard: every valid cycle (stalled or not) must show the expected head word.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_idx = 0;
    end else if (out_valid) begin
      if (expq.size() == 0) begin
        check("spurious_valid", 32'(out_valid), 32'd0);
      end else begin
        check("out_data", 32'(out_data), 32'(expq[0]));
        check("out_index", 32'(out_index), exp_idx);
        check("out_last", 32'(out_last), 32'(exp_idx == 3));
        if (out_ready) begin
          void'(expq.pop_front());
          exp_idx = (exp_idx + 1) % 4;
          xfers++;
        end
      end
    end else begin
      check("last_idle", 32'(out_last), 32'd0);
    end
  end

  task automatic push_exp(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input logic [3:0] d);
    expq.push_back(a); expq.push_back(b); expq.push_back(c); expq.push_back(d);
  endtask

  // Called just after a posedge; returns just after the posedge that accepted the word.
  task automatic send(input logic [3:0] d);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!ok) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && expq.size() > 0; i++) begin
      @(posedge clk); #1;
    end
    check("drain", expq.size(), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    in_valid8 = 1'b0; in_data8 = '0; out_ready8 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_index", 32'(out_index), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single frame then back-to-back frame: latency and contiguity
    push_exp(4'd6, 4'd0, 4'd2, 4'd7);
    push_exp(4'd1, 4'd5, 4'd3, 4'd9);
    send(4'd6); send(4'd2); send(4'd0);
    check("lat_pre", 32'(out_valid), 32'd0);
    send(4'd7);
    check("lat_first", 32'(out_valid), 32'd1);
    x0 = xfers;
    send(4'd1); send(4'd3); send(4'd5); send(4'd9);
    check("b2b_mid", xfers - x0, 32'd4);
    repeat (4) @(posedge clk);
    #1;
    check("b2b_end", xfers - x0, 32'd8);
    @(negedge clk);
    check("b2b_idle", 32'(out_valid), 32'd0);
    @(posedge clk); #1;

    // Backpressure: two banks fill, ninth word refused until a bank drains
    out_ready = 1'b0;
    push_exp(4'd1, 4'd2, 4'd3, 4'd4);
    push_exp(4'd8, 4'd10, 4'd9, 4'd11);
    push_exp(4'd12, 4'd14, 4'd13, 4'd15);
    send(4'd1); send(4'd3); send(4'd2); send(4'd4);
    send(4'd8); send(4'd9); send(4'd10); send(4'd11);
    check("full_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1; in_data = 4'd12;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_hold", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("drain_ready_lo", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    check("drain_ready_hi", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    send(4'd13); send(4'd14); send(4'd15);
    drain();

    // Random stalls while two frames stream in
    push_exp(4'd4, 4'd15, 4'd8, 4'd14);
    push_exp(4'd6, 4'd0, 4'd2, 4'd7);
    fork
      begin
        send(4'd4); send(4'd8); send(4'd15); send(4'd14);
        send(4'd6); send(4'd2); send(4'd0); send(4'd7);
      end
      begin
        repeat (40) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset mid-frame discards the partial frame
    send(4'd3); send(4'd5);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_data", 32'(out_data), 32'd0);
    check("mid_rst_out_index", 32'(out_index), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    push_exp(4'd6, 4'd0, 4'd2, 4'd7);
    send(4'd6); send(4'd2); send(4'd0);
    check("post_rst_valid", 32'(out_valid), 32'd0);
    send(4'd7);
    drain();

    // SAMPLES=8 reorder
    for (int k = 0; k < 8; k++) begin
      in_valid8 = 1'b1; in_data8 = 4'(k);
      @(negedge clk);
      check("in_ready8", 32'(in_ready8), 32'd1);
      @(posedge clk); #1;
    end
    in_valid8 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("out_valid8", 32'(out_valid8), 32'd1);
      check("out_data8", 32'(out_data8), 32'(exp8[k]));
      check("out_index8", 32'(out_index8), 32'(k));
      check("out_last8", 32'(out_last8), 32'(k == 7));
    end
    @(negedge clk);
    check("idle8", 32'(out_valid8), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
